// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared types and constants for the GB cartridge bus front-end
package gb_bus_pkg;
   typedef enum logic [1:0] {IDLE, WR_LOW, WR_OK} wr_state_e;
   localparam logic GB_REG_WIN = 1'b0;
   localparam logic [2:0] GB_RAM_WIN = 3'b101;
   // synced vector layout {RST, RD, WR, CS, D[7:0], A[3:0]}; idle bus levels
   localparam logic [15:0] SYNC_RST = {1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0};
endpackage

// File: rtl/gb_bus_if.sv
// gb_bus_if: raw GB cartridge bus inputs and qualified write outputs
interface gb_bus_if;
   logic [3:0] GB_A;
   logic [7:0] GB_D;
   logic GB_CS;
   logic GB_WR;
   logic GB_RD;
   logic GB_RST;
   logic WR_STB;
   logic [3:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic REG_WR;
   logic RAM_WR;
   logic RD_ACT;
   logic BUS_RST_N;
   logic [7:0] GLITCH_CNT;
   modport master (
      output GB_A, GB_D, GB_CS, GB_WR, GB_RD, GB_RST,
      input  WR_STB, WR_ADDR, WR_DATA, REG_WR, RAM_WR, RD_ACT, BUS_RST_N, GLITCH_CNT
   );
   modport slave (
      input  GB_A, GB_D, GB_CS, GB_WR, GB_RD, GB_RST,
      output WR_STB, WR_ADDR, WR_DATA, REG_WR, RAM_WR, RD_ACT, BUS_RST_N, GLITCH_CNT
   );
endinterface

// File: rtl/gb_sync.sv
// gb_sync: W-bit x STAGES flop chain with per-bit reset value
module gb_sync #(
   parameter int W = 16,
   parameter int STAGES = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] r [STAGES];
   always_ff @(posedge clk) begin
      if (rst) for (int i = 0; i < STAGES; i++) r[i] <= RST_VAL;
      else begin
         r[0] <= d;
         for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
      end
   end
   assign q = r[STAGES-1];
endmodule

// File: rtl/gb_bus_frontend.sv
// gb_bus_frontend: synchronizes the GB bus and emits one filtered strobe per completed write
module gb_bus_frontend
   import gb_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 3
) (
   input logic CLK,
   input logic RST,
   gb_bus_if.slave bus
);
   localparam int CW = $clog2(FILT_CYCLES + 1);
   logic [15:0] s;
   logic s_rst, s_rd, s_wr, unused_cs;
   logic [7:0] s_d;
   logic [3:0] s_a;
   wr_state_e state, nxt;
   logic [CW-1:0] cnt, nxt_cnt;
   logic cap, glitch_inc, stb;
   logic [3:0] cap_a, wr_addr;
   logic [7:0] cap_d, wr_data, glitch_cnt;
   logic wr_stb, reg_wr, ram_wr, rd_act;

   gb_sync #(.W(16), .STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST)) u_sync (
      .clk(CLK), .rst(RST),
      .d({bus.GB_RST, bus.GB_RD, bus.GB_WR, bus.GB_CS, bus.GB_D, bus.GB_A}),
      .q(s)
   );
   assign {s_rst, s_rd, s_wr, unused_cs, s_d, s_a} = s;

   // console reset overrides everything, including a WR rise in the same cycle
   always_comb begin
      nxt = state;
      nxt_cnt = cnt;
      cap = 1'b0;
      glitch_inc = 1'b0;
      stb = 1'b0;
      if (!s_rst) nxt = IDLE;
      else case (state)
         IDLE: if (!s_wr) begin
            nxt = (FILT_CYCLES == 1) ? WR_OK : WR_LOW;
            nxt_cnt = CW'(1);
            cap = 1'b1;
         end
         WR_LOW: if (!s_wr) begin
            nxt_cnt = cnt + CW'(1);
            cap = 1'b1;
            nxt = (nxt_cnt == CW'(FILT_CYCLES)) ? WR_OK : WR_LOW;
         end else begin
            nxt = IDLE;
            glitch_inc = 1'b1;
         end
         WR_OK: if (!s_wr) cap = 1'b1;
         else begin
            nxt = IDLE;
            stb = 1'b1;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
         cap_a <= '0;
         cap_d <= '0;
      end else begin
         state <= nxt;
         cnt <= nxt_cnt;
         if (cap) begin
            cap_a <= s_a;
            cap_d <= s_d;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_stb <= 1'b0;
         reg_wr <= 1'b0;
         ram_wr <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         rd_act <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         wr_stb <= stb;
         reg_wr <= stb && (cap_a[3] == GB_REG_WIN);
         ram_wr <= stb && (cap_a[3:1] == GB_RAM_WIN);
         if (stb) begin
            wr_addr <= cap_a;
            wr_data <= cap_d;
         end
         rd_act <= !s_rd && s_rst;
         if (glitch_inc && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
      end
   end

   assign bus.WR_STB = wr_stb;
   assign bus.WR_ADDR = wr_addr;
   assign bus.WR_DATA = wr_data;
   assign bus.REG_WR = reg_wr;
   assign bus.RAM_WR = ram_wr;
   assign bus.RD_ACT = rd_act;
   assign bus.BUS_RST_N = s_rst;
   assign bus.GLITCH_CNT = glitch_cnt;
endmodule

// File: tb/tb_gb_bus_frontend.sv
// tb_gb_bus_frontend: directed checks of write filtering, strobe timing and reset behaviour
module tb_gb_bus_frontend;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   int n_stb, pos, pos2, tot_stb;
   logic [3:0] s_addr, s_addr2;
   logic [7:0] s_data, s_data2;
   logic s_reg, s_ram, s_reg2;

   gb_bus_if bus ();
   gb_bus_frontend #(.SYNC_STAGES(2), .FILT_CYCLES(3)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // WR is raised at the current negedge; observe six following negedges
   task automatic watch();
      n_stb = 0;
      pos = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.WR_STB === 1'b1) begin
            n_stb++;
            pos = k;
            s_addr = bus.WR_ADDR;
            s_data = bus.WR_DATA;
            s_reg = bus.REG_WR;
            s_ram = bus.RAM_WR;
         end
      end
   endtask

   task automatic wr_cycle(input logic [3:0] a, input logic [7:0] d0, input logic [7:0] d1, input int low);
      bus.GB_A = a;
      bus.GB_D = d0;
      bus.GB_WR = 1'b0;
      for (int i = 0; i < low; i++) begin
         if (i == low - 1) bus.GB_D = d1;
         @(negedge clk);
      end
      bus.GB_WR = 1'b1;
      watch();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stb"}, bus.WR_STB, 1'b0);
      chk({tag, "_reg"}, bus.REG_WR, 1'b0);
      chk({tag, "_ram"}, bus.RAM_WR, 1'b0);
      chk({tag, "_rd"}, bus.RD_ACT, 1'b0);
      chk({tag, "_addr"}, bus.WR_ADDR, 4'h0);
      chk({tag, "_data"}, bus.WR_DATA, 8'h00);
      chk({tag, "_glitch"}, bus.GLITCH_CNT, 8'h00);
      chk({tag, "_busrst"}, bus.BUS_RST_N, 1'b0);
   endtask

   initial begin
      bus.GB_A = 4'h0;
      bus.GB_D = 8'h00;
      bus.GB_CS = 1'b1;
      bus.GB_WR = 1'b1;
      bus.GB_RD = 1'b1;
      bus.GB_RST = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      bus.GB_RST = 1'b1;
      repeat (4) @(negedge clk);
      chk("busrst_hi", bus.BUS_RST_N, 1'b1);
      chk("rdact_idle", bus.RD_ACT, 1'b0);
      // RD_ACT lags raw RD by three edges
      bus.GB_RD = 1'b0;
      repeat (2) @(negedge clk);
      chk("rdact_lag2", bus.RD_ACT, 1'b0);
      @(negedge clk);
      chk("rdact_lag3", bus.RD_ACT, 1'b1);
      bus.GB_RD = 1'b1;
      repeat (4) @(negedge clk);
      chk("rdact_off", bus.RD_ACT, 1'b0);

      wr_cycle(4'h2, 8'h05, 8'h05, 10);
      chk("w1_n", n_stb, 1);
      chk("w1_pos", pos, 3);
      chk("w1_addr", s_addr, 4'h2);
      chk("w1_data", s_data, 8'h05);
      chk("w1_reg", s_reg, 1'b1);
      chk("w1_ram", s_ram, 1'b0);
      chk("w1_hold_addr", bus.WR_ADDR, 4'h2);

      wr_cycle(4'h1, 8'h77, 8'h77, 2);
      chk("g1_n", n_stb, 0);
      chk("g1_cnt", bus.GLITCH_CNT, 8'd1);
      chk("g1_hold_data", bus.WR_DATA, 8'h05);
      wr_cycle(4'h1, 8'h77, 8'h77, 1);
      chk("g2_n", n_stb, 0);
      chk("g2_cnt", bus.GLITCH_CNT, 8'd2);

      wr_cycle(4'h6, 8'h42, 8'h42, 3);
      chk("exact_n", n_stb, 1);
      chk("exact_pos", pos, 3);
      chk("exact_data", s_data, 8'h42);
      chk("exact_reg", s_reg, 1'b1);

      wr_cycle(4'hA, 8'h11, 8'h3C, 5);
      chk("late_n", n_stb, 1);
      chk("late_data", s_data, 8'h3C);
      chk("late_ram", s_ram, 1'b1);
      chk("late_reg", s_reg, 1'b0);

      // console reset while the write is already accepted
      bus.GB_A = 4'h3;
      bus.GB_D = 8'h55;
      bus.GB_WR = 1'b0;
      repeat (6) @(negedge clk);
      bus.GB_RST = 1'b0;
      repeat (2) @(negedge clk);
      bus.GB_WR = 1'b1;
      watch();
      chk("gbrst_n", n_stb, 0);
      chk("gbrst_busrst", bus.BUS_RST_N, 1'b0);
      chk("gbrst_glitch", bus.GLITCH_CNT, 8'd2);
      chk("gbrst_data", bus.WR_DATA, 8'h3C);
      bus.GB_RST = 1'b1;
      repeat (4) @(negedge clk);

      // back-to-back writes with one raw high sample between them
      bus.GB_A = 4'h0;
      bus.GB_D = 8'h0A;
      bus.GB_WR = 1'b0;
      repeat (4) @(negedge clk);
      bus.GB_WR = 1'b1;
      n_stb = 0;
      pos = 0;
      pos2 = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus.WR_STB === 1'b1) begin
            n_stb++;
            if (n_stb == 1) begin
               pos = k;
               s_addr = bus.WR_ADDR;
               s_data = bus.WR_DATA;
               s_reg = bus.REG_WR;
            end else begin
               pos2 = k;
               s_addr2 = bus.WR_ADDR;
               s_data2 = bus.WR_DATA;
               s_reg2 = bus.REG_WR;
            end
         end
         if (k == 1) begin
            bus.GB_A = 4'h4;
            bus.GB_D = 8'h03;
            bus.GB_WR = 1'b0;
         end
         if (k == 5) bus.GB_WR = 1'b1;
      end
      chk("b2b_n", n_stb, 2);
      chk("b2b_pos1", pos, 3);
      chk("b2b_addr1", s_addr, 4'h0);
      chk("b2b_data1", s_data, 8'h0A);
      chk("b2b_reg1", s_reg, 1'b1);
      chk("b2b_pos2", pos2, 8);
      chk("b2b_addr2", s_addr2, 4'h4);
      chk("b2b_data2", s_data2, 8'h03);
      chk("b2b_reg2", s_reg2, 1'b1);

      tot_stb = 0;
      for (int g = 0; g < 300; g++) begin
         bus.GB_WR = 1'b0;
         repeat (2) begin
            @(negedge clk);
            if (bus.WR_STB === 1'b1) tot_stb++;
         end
         bus.GB_WR = 1'b1;
         repeat (2) begin
            @(negedge clk);
            if (bus.WR_STB === 1'b1) tot_stb++;
         end
      end
      repeat (4) @(negedge clk);
      chk("sat_cnt", bus.GLITCH_CNT, 8'd255);
      chk("sat_nostb", tot_stb, 0);

      // host reset in the middle of an accepted write
      bus.GB_A = 4'hB;
      bus.GB_D = 8'h99;
      bus.GB_WR = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("midrst");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.GB_WR = 1'b1;
      watch();
      chk("postrst_n", n_stb, 1);
      chk("postrst_pos", pos, 3);
      chk("postrst_addr", s_addr, 4'hB);
      chk("postrst_data", s_data, 8'h99);
      chk("postrst_ram", s_ram, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
